// File: rtl/mul_scheduler_pkg.sv
// Shared types and default sizes for the multiplier scheduler.
// Holds the FSM state encoding and default width/count/timeout constants.
package mul_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int C_WIDTH_DEF = 32;
  localparam int N_REQ_DEF   = 4;
  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/mul_scheduler_rr_arbiter.sv
// Round-robin winner search, purely combinational.
// Ports: req (requests), last_served -> winner (one-hot), idx (winner index).
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_served,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] p;
  logic          found;

  // Walk from last_served+1 around the ring; first hit wins.
  always_comb begin
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    p      = '0;
    for (int k = 1; k <= N; k++) begin
      p = IW'((int'(last_served) + k) % N);
      if (!found && req[p]) begin
        found     = 1'b1;
        winner[p] = 1'b1;
        idx       = p;
      end
    end
  end

endmodule

// File: rtl/mul_scheduler.sv
// Shares one multiplier among N_REQ requesters with round-robin service.
// Ports: ctl_clk, reset (async low), req/req_a/req_b/req_signed in,
//   grant/rsp_valid/rsp_y/rsp_err out, mul_* multiplier handshake.
module mul_scheduler
  import mul_scheduler_pkg::*;
#(
  parameter int C_WIDTH = C_WIDTH_DEF,
  parameter int N_REQ   = N_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                       ctl_clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*C_WIDTH-1:0]   req_a,
  input  logic [N_REQ*C_WIDTH-1:0]   req_b,
  input  logic [N_REQ-1:0]           req_signed,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [C_WIDTH-1:0]         rsp_y,
  output logic                       rsp_err,
  output logic [C_WIDTH-1:0]         mul_a,
  output logic [C_WIDTH-1:0]         mul_b,
  output logic                       mul_signed,
  output logic                       mul_trigger,
  input  logic                       mul_ready,
  input  logic                       mul_done,
  input  logic [C_WIDTH-1:0]         mul_y
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t            state;
  state_t            state_nx;
  logic [IW-1:0]     last_served;
  logic [IW-1:0]     owner;
  logic [IW-1:0]     win_idx;
  logic [N_REQ-1:0]  win_oh;
  logic [N_REQ-1:0]  owner_oh;
  logic [CW-1:0]     cnt;
  logic              trig_q;
  logic              start;
  logic              timed_out;

  assign start     = (|req) && mul_ready;
  assign timed_out = !mul_done && (cnt == CW'(TIMEOUT));
  assign owner_oh  = N_REQ'(1) << owner;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .req         (req),
    .last_served (last_served),
    .winner      (win_oh),
    .idx         (win_idx)
  );

  always_ff @(posedge ctl_clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (mul_done || timed_out) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: operands latch only on a grant, so they hold until
  // the next departure from IDLE.
  always_ff @(posedge ctl_clk or negedge reset) begin
    if (!reset) begin
      mul_a       <= '0;
      mul_b       <= '0;
      mul_signed  <= 1'b0;
      owner       <= '0;
      last_served <= IW'(N_REQ - 1);
      cnt         <= '0;
      rsp_y       <= '0;
      rsp_err     <= 1'b0;
      trig_q      <= 1'b0;
    end else begin
      trig_q <= (state == S_ISSUE);
      unique case (state)
        S_IDLE: begin
          if (start) begin
            mul_a      <= req_a[int'(win_idx)*C_WIDTH +: C_WIDTH];
            mul_b      <= req_b[int'(win_idx)*C_WIDTH +: C_WIDTH];
            mul_signed <= req_signed[win_idx];
            owner      <= win_idx;
          end
        end
        S_ISSUE: cnt <= '0;
        S_WAIT: begin
          if (mul_done) begin
            rsp_y   <= mul_y;
            rsp_err <= 1'b0;
          end else if (timed_out) begin
            rsp_y   <= '0;
            rsp_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: last_served <= owner;
        default: ;
      endcase
    end
  end

  // Grant shows in ISSUE, trigger one cycle later, response in RESP.
  always_comb begin
    grant     = '0;
    rsp_valid = '0;
    unique case (1'b1)
      (state == S_ISSUE): grant     = owner_oh;
      (state == S_RESP):  rsp_valid = owner_oh;
      default: ;
    endcase
  end

  assign mul_trigger = trig_q;

  // win_oh is kept for visibility; index drives the datapath.
  logic unused_ok;
  assign unused_ok = ^win_oh;

endmodule

// File: tb/tb_mul_scheduler.sv
// Directed bench for mul_scheduler with a fixed-point (Q.8) multiplier model.
// Drives/samples on the falling clock edge; prints one summary line.
module tb_mul_scheduler;

  localparam int CW = 32;
  localparam int NR = 4;
  localparam int TO = 20;

  logic              ctl_clk;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR*CW-1:0]  req_a;
  logic [NR*CW-1:0]  req_b;
  logic [NR-1:0]     req_signed;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     rsp_valid;
  logic [CW-1:0]     rsp_y;
  logic              rsp_err;
  logic [CW-1:0]     mul_a;
  logic [CW-1:0]     mul_b;
  logic              mul_signed;
  logic              mul_trigger;
  logic              mul_ready;
  logic              mul_done;
  logic [CW-1:0]     mul_y;

  int checks = 0;
  int errors = 0;
  int oh_bad = 0;

  mul_scheduler #(
    .C_WIDTH (CW),
    .N_REQ   (NR),
    .TIMEOUT (TO)
  ) dut (
    .ctl_clk     (ctl_clk),
    .reset       (reset),
    .req         (req),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_signed  (req_signed),
    .grant       (grant),
    .rsp_valid   (rsp_valid),
    .rsp_y       (rsp_y),
    .rsp_err     (rsp_err),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_signed  (mul_signed),
    .mul_trigger (mul_trigger),
    .mul_ready   (mul_ready),
    .mul_done    (mul_done),
    .mul_y       (mul_y)
  );

  initial ctl_clk = 1'b0;
  always #5 ctl_clk = ~ctl_clk;

  // Multiplier model: Q.8 fixed point, m_lat extra cycles after trigger.
  logic          m_trig, m_s, m_busy, m_hang;
  logic [CW-1:0] m_a, m_b, m_res;
  int            m_lat, m_left;
  logic          stray_req, stray_ack;

  function automatic logic [31:0] fx(input logic [31:0] a, input logic [31:0] b,
                                     input logic s);
    logic [63:0] p;
    if (s) p = 64'(longint'($signed(a)) * longint'($signed(b)));
    else   p = {32'h0, a} * {32'h0, b};
    return p[39:8];
  endfunction

  always @(negedge ctl_clk) begin
    m_trig = mul_trigger;
    m_a    = mul_a;
    m_b    = mul_b;
    m_s    = mul_signed;
    if ($countones(grant) > 1 || $countones(rsp_valid) > 1) oh_bad++;
  end

  initial begin
    mul_done  = 1'b0;
    mul_y     = '0;
    m_busy    = 1'b0;
    m_left    = 0;
    m_res     = '0;
    stray_ack = 1'b0;
  end

  always @(posedge ctl_clk) begin
    #1;
    mul_done = 1'b0;
    if (!reset) begin
      m_busy = 1'b0;
    end else begin
      if (m_trig && !m_hang) begin
        m_busy = 1'b1;
        m_left = m_lat;
        m_res  = fx(m_a, m_b, m_s);
      end
      if (m_busy) begin
        if (m_left == 0) begin
          mul_done = 1'b1;
          mul_y    = m_res;
          m_busy   = 1'b0;
        end else begin
          m_left--;
        end
      end
    end
    if (stray_req != stray_ack) begin
      mul_done  = 1'b1;
      stray_ack = stray_req;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_grant(input int lim);
    int n;
    n = 0;
    do begin
      @(negedge ctl_clk);
      n++;
    end while (grant == '0 && n < lim);
  endtask

  task automatic wait_rsp(input int lim, output int n, output logic pd);
    n  = 0;
    pd = 1'b0;
    while (rsp_valid == '0 && n < lim) begin
      pd = mul_done;
      @(negedge ctl_clk);
      n++;
    end
  endtask

  task automatic set_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic s);
    req_a[idx*CW +: CW] = a;
    req_b[idx*CW +: CW] = b;
    req_signed[idx]     = s;
  endtask

  // One full transaction from IDLE; returns in the IDLE cycle after RESP.
  task automatic serve(input string nm, input int idx, input logic [31:0] a,
                       input logic [31:0] b, input logic s, input logic [31:0] y);
    int   n;
    logic pd;
    set_op(idx, a, b, s);
    req = NR'(1) << idx;
    @(negedge ctl_clk);
    chk({nm, ".grant"}, 32'(grant), 32'(NR'(1) << idx));
    req = '0;
    @(negedge ctl_clk);
    chk({nm, ".trigger"}, 32'(mul_trigger), 32'd1);
    chk({nm, ".mul_a"}, mul_a, a);
    chk({nm, ".mul_b"}, mul_b, b);
    chk({nm, ".mul_signed"}, 32'(mul_signed), 32'(s));
    wait_rsp(50, n, pd);
    chk({nm, ".rsp_valid"}, 32'(rsp_valid), 32'(NR'(1) << idx));
    chk({nm, ".done_lat"}, 32'(pd), 32'd1);
    chk({nm, ".rsp_y"}, rsp_y, y);
    chk({nm, ".rsp_err"}, 32'(rsp_err), 32'd0);
    @(negedge ctl_clk);
  endtask

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] y;
  } vec_t;

  vec_t vt[6];

  initial begin
    int   n;
    int   cnt;
    logic pd;
    logic [NR-1:0] g;

    vt[0] = '{2, 32'h0000_0300, 32'h0000_0200, 1'b0, 32'h0000_0600};
    vt[1] = '{1, 32'hFFFF_FE00, 32'h0000_0180, 1'b1, 32'hFFFF_FD00};
    vt[2] = '{3, 32'h0000_1000, 32'h0000_1000, 1'b0, 32'h0001_0000};
    vt[3] = '{0, 32'hFFFF_FF00, 32'hFFFF_FE00, 1'b1, 32'h0000_0200};
    vt[4] = '{2, 32'hFFFF_FF00, 32'h0000_0100, 1'b0, 32'hFFFF_FF00};
    vt[5] = '{1, 32'h0000_0280, 32'hFFFF_FF80, 1'b1, 32'hFFFF_FEC0};

    reset      = 1'b0;
    req        = '0;
    req_a      = '0;
    req_b      = '0;
    req_signed = '0;
    mul_ready  = 1'b1;
    m_lat      = 0;
    m_hang     = 1'b0;
    stray_req  = 1'b0;

    repeat (2) @(negedge ctl_clk);
    chk("rst.ctl", 32'({grant, rsp_valid, mul_trigger, rsp_err}), 32'd0);
    chk("rst.rsp_y", rsp_y, 32'd0);
    chk("rst.mul_ab", mul_a | mul_b, 32'd0);
    chk("rst.mul_signed", 32'(mul_signed), 32'd0);
    reset = 1'b1;
    @(negedge ctl_clk);

    for (int i = 0; i < 6; i++) begin
      m_lat = i % 3;
      serve($sformatf("vec%0d", i), vt[i].idx, vt[i].a, vt[i].b, vt[i].s, vt[i].y);
    end

    // All four held from reset: 0,1,2,3,0 with an IDLE gap each time.
    reset = 1'b0;
    @(negedge ctl_clk);
    reset = 1'b1;
    m_lat = 1;
    for (int i = 0; i < NR; i++) set_op(i, 32'((i + 1) << 8), 32'h100, 1'b0);
    req = '1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(10);
      chk($sformatf("rr%0d.grant", k), 32'(grant), 32'(NR'(1) << (k % NR)));
      g = grant;
      wait_rsp(50, n, pd);
      chk($sformatf("rr%0d.rsp_valid", k), 32'(rsp_valid), 32'(g));
      chk($sformatf("rr%0d.rsp_y", k), rsp_y, 32'(((k % NR) + 1) << 8));
      @(negedge ctl_clk);
      chk($sformatf("rr%0d.idle_gap", k), 32'(grant), 32'd0);
      if (k == 4) req = '0;
    end
    @(negedge ctl_clk);

    // Timeout, then a normal request.
    m_hang = 1'b1;
    set_op(1, 32'h300, 32'h200, 1'b0);
    req = 4'b0010;
    @(negedge ctl_clk);
    chk("to.grant", 32'(grant), 32'h2);
    req = '0;
    @(negedge ctl_clk);
    chk("to.trigger", 32'(mul_trigger), 32'd1);
    n = 0;
    do begin
      @(negedge ctl_clk);
      n++;
    end while (rsp_valid == '0 && n < 100);
    chk("to.latency", 32'(n), 32'(TO + 1));
    chk("to.rsp_valid", 32'(rsp_valid), 32'h2);
    chk("to.rsp_err", 32'(rsp_err), 32'd1);
    chk("to.rsp_y", rsp_y, 32'd0);
    m_hang = 1'b0;
    @(negedge ctl_clk);
    serve("after_to", 2, 32'h300, 32'h200, 1'b0, 32'h600);

    // Reset in WAIT aborts the transaction.
    m_hang = 1'b1;
    set_op(1, 32'h1234, 32'h5678, 1'b1);
    req = 4'b0010;
    @(negedge ctl_clk);
    req = '0;
    repeat (3) @(negedge ctl_clk);
    reset = 1'b0;
    #1;
    chk("rw.ctl", 32'({grant, rsp_valid, mul_trigger, rsp_err}), 32'd0);
    chk("rw.rsp_y", rsp_y, 32'd0);
    chk("rw.mul_ab", mul_a | mul_b, 32'd0);
    chk("rw.mul_signed", 32'(mul_signed), 32'd0);
    cnt = 0;
    repeat (3) begin
      @(negedge ctl_clk);
      if (rsp_valid != '0) cnt++;
    end
    chk("rw.no_rsp", 32'(cnt), 32'd0);
    m_hang = 1'b0;
    m_lat  = 0;
    set_op(0, 32'h400, 32'h200, 1'b0);
    set_op(3, 32'h100, 32'h100, 1'b0);
    reset = 1'b1;
    req   = 4'b1001;
    @(negedge ctl_clk);
    chk("rw.first_grant", 32'(grant), 32'h1);
    req = 4'b1000;
    wait_rsp(50, n, pd);
    chk("rw.rsp0", 32'(rsp_valid), 32'h1);
    chk("rw.rsp0_y", rsp_y, 32'h800);
    wait_grant(10);
    chk("rw.second_grant", 32'(grant), 32'h8);
    req = '0;
    wait_rsp(50, n, pd);
    chk("rw.rsp3", 32'(rsp_valid), 32'h8);
    chk("rw.rsp3_y", rsp_y, 32'h100);
    @(negedge ctl_clk);

    // mul_ready gating, then a stray mul_done while idle.
    mul_ready = 1'b0;
    set_op(1, 32'h200, 32'h200, 1'b0);
    req = 4'b0010;
    cnt = 0;
    repeat (5) begin
      @(negedge ctl_clk);
      if (grant != '0) cnt++;
    end
    chk("rdy.no_grant", 32'(cnt), 32'd0);
    mul_ready = 1'b1;
    @(negedge ctl_clk);
    chk("rdy.grant", 32'(grant), 32'h2);
    req = '0;
    wait_rsp(50, n, pd);
    chk("rdy.rsp_y", rsp_y, 32'h400);
    @(negedge ctl_clk);
    stray_req = ~stray_req;
    cnt = 0;
    repeat (5) begin
      @(negedge ctl_clk);
      if (rsp_valid != '0) cnt++;
    end
    chk("stray.no_rsp", 32'(cnt), 32'd0);
    serve("after_stray", 3, 32'hFFFF_FE00, 32'hFFFF_FE00, 1'b1, 32'h400);

    chk("onehot", 32'(oh_bad), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
